// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: per-stage stall_n/flush
// from hazard inputs, a small FSM for multi-cycle conditions, and a stall counter.
//   state    | meaning
//   RUN      | normal issue, single-cycle hazards only
//   MDU_WAIT | multi-cycle MDU op outstanding, PC/ID/EX frozen
//   REDIR    | redirect taken, discarding the in-flight wrong-path fetch
module pipe_hazard_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_en,
  input  logic             id_rs2_en,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rd_wen,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall_n_pc,
  output logic             stall_n_id,
  output logic             stall_n_ex,
  output logic             stall_n_mem,
  output logic             stall_n_wb,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_mem,
  output logic             flush_wb,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    REDIR    = 2'd2
  } state_t;

  state_t state, state_nxt;

  // XLEN is carried for integration only; no datapath passes through here.
  if (XLEN < 1) begin : g_xlen_check
  end

  logic mem_wait, mdu_busy, redirect, drain, load_use, fetch_wait;

  assign mem_wait   = dmem_req && !dmem_ready;
  assign mdu_busy   = !mdu_done && ((state == MDU_WAIT) || (state == RUN && ex_mdu_start));
  assign redirect   = ex_redirect && (state == RUN);
  assign drain      = (state == REDIR);
  assign load_use   = ex_is_load && ex_rd_wen && (ex_rd != 5'd0) &&
                      ((id_rs1_en && (id_rs1 == ex_rd)) || (id_rs2_en && (id_rs2 == ex_rd)));
  assign fetch_wait = !imem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (ex_mdu_start && !mdu_done)     state_nxt = MDU_WAIT;
        else if (ex_redirect && stall_n_ex) state_nxt = REDIR;
      end
      MDU_WAIT: if (mdu_done)   state_nxt = RUN;
      REDIR:    if (imem_ready) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // Rules applied lowest priority first so each higher rule overwrites the
  // stages it owns; every rule sets both stall_n and flush of those stages.
  always_comb begin
    stall_n_pc  = 1'b1;
    stall_n_id  = 1'b1;
    stall_n_ex  = 1'b1;
    stall_n_mem = 1'b1;
    stall_n_wb  = 1'b1;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    flush_mem   = 1'b0;
    flush_wb    = 1'b0;
    if (fetch_wait) begin
      stall_n_pc = 1'b0;
      stall_n_id = 1'b1; flush_id = 1'b1;
    end
    if (load_use) begin
      stall_n_pc = 1'b0;
      stall_n_id = 1'b0; flush_id = 1'b0;
      stall_n_ex = 1'b1; flush_ex = 1'b1;
    end
    if (drain) begin
      stall_n_pc = 1'b1;
      stall_n_id = 1'b1; flush_id = 1'b1;
    end
    if (redirect) begin
      stall_n_pc = 1'b1;
      stall_n_id = 1'b1; flush_id = 1'b1;
      stall_n_ex = 1'b1; flush_ex = 1'b1;
    end
    if (mdu_busy) begin
      stall_n_pc  = 1'b0;
      stall_n_id  = 1'b0; flush_id  = 1'b0;
      stall_n_ex  = 1'b0; flush_ex  = 1'b0;
      stall_n_mem = 1'b1; flush_mem = 1'b1;
    end
    if (mem_wait) begin
      stall_n_pc  = 1'b0;
      stall_n_id  = 1'b0; flush_id  = 1'b0;
      stall_n_ex  = 1'b0; flush_ex  = 1'b0;
      stall_n_mem = 1'b0; flush_mem = 1'b0;
      stall_n_wb  = 1'b1; flush_wb  = 1'b1;
    end
    if (!rst_n) begin
      stall_n_pc  = 1'b1;
      stall_n_id  = 1'b1;
      stall_n_ex  = 1'b1;
      stall_n_mem = 1'b1;
      stall_n_wb  = 1'b1;
      flush_id    = 1'b0;
      flush_ex    = 1'b0;
      flush_mem   = 1'b0;
      flush_wb    = 1'b0;
    end
  end

  assign ctrl_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (!stall_n_pc && (stall_cycles != {CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage in-order pipeline. It drives the `stall_n`/`flush` pair of every inter-stage register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). Its inputs are load-use hazards, EX-stage redirects, multi-cycle MDU operations and instruction/data memory handshakes. A small FSM tracks multi-cycle conditions, and a saturating counter records stall cycles for performance tuning.

## Interface
- `XLEN`, default 64: pipeline data width (informational; no datapath passes through).
- `CNT_W`, default 16: width of the stall-cycle counter.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `id_rs1`, `id_rs2`, in, 5 each: source registers of the instruction in ID.
- `id_rs1_en`, `id_rs2_en`, in, 1 each: the corresponding source is actually read.
- `ex_rd`, in, 5: destination register of the instruction in EX.
- `ex_rd_wen`, in, 1: the EX instruction writes `ex_rd`.
- `ex_is_load`, in, 1: the EX instruction is a load.
- `ex_redirect`, in, 1: the EX branch/jump resolved to a non-sequential PC. Held while EX is frozen.
- `ex_mdu_start`, in, 1: an MDU op in EX is issuing. High for one cycle per op.
- `mdu_done`, in, 1: MDU result valid, one-cycle pulse.
- `imem_ready`, in, 1: fetch response valid this cycle.
- `dmem_req`, in, 1: the MEM stage holds a load/store.
- `dmem_ready`, in, 1: data memory accepted/returned this cycle.
- `stall_n_pc`, `stall_n_id`, `stall_n_ex`, `stall_n_mem`, `stall_n_wb`, out, 1 each: a register loads when 1 and holds when 0.
- `flush_id`, `flush_ex`, `flush_mem`, `flush_wb`, out, 1 each: the register loads zeros (a bubble). Asserted only together with its `stall_n`=1.
- `ctrl_state`, out, 2: current FSM state.
- `stall_cycles`, out, CNT_W: saturating count of cycles with `stall_n_pc`=0.

## Operation
- **FSM states:** RUN=0, MDU_WAIT=1, REDIR=2.
  - RUN→MDU_WAIT on `ex_mdu_start` && !`mdu_done`.
  - MDU_WAIT→RUN on `mdu_done`.
  - RUN→REDIR on `ex_redirect` when EX is not frozen (`stall_n_ex`=1 or `flush_ex` path active).
  - REDIR→RUN on `imem_ready`.
  - MDU_WAIT ignores `ex_redirect`.
- **Default:** all `stall_n`=1 and all flush=0.
- **Priority rules, highest first.** A higher rule's assignments win; lower rules only fill stages left untouched.
  1. **Memory wait** (`dmem_req` && !`dmem_ready`): `stall_n_pc`, `stall_n_id`, `stall_n_ex`, `stall_n_mem` =0; `flush_wb`=1.
  2. **MDU busy** (state MDU_WAIT && !`mdu_done`, or RUN && `ex_mdu_start` && !`mdu_done`): PC, ID and EX hold; `flush_mem`=1.
  3. **Redirect** (`ex_redirect` in RUN): `flush_id`=1, `flush_ex`=1, PC loads the target.
  4. **REDIR drain:** while in REDIR, `flush_id`=1. This discards the single wrong-path fetch response still in flight. PC loads normally.
  5. **Load-use:** `ex_is_load` && `ex_rd_wen` && `ex_rd`≠0 && ((`id_rs1_en` && `id_rs1`==`ex_rd`) || (`id_rs2_en` && `id_rs2`==`ex_rd`)). PC and ID hold; `flush_ex`=1.
  6. **Fetch wait** (!`imem_ready`): PC holds; `flush_id`=1.
- **Redirect vs. load-use:** redirect wins. The ID instruction is wrong-path anyway.
- **`stall_cycles`:** increments by 1 each cycle `stall_n_pc`=0 and saturates at 2^CNT_W−1.

## Timing
- All `stall_n`/`flush` outputs are combinational from state plus inputs, with zero-cycle latency.
- `ctrl_state` and `stall_cycles` are registered and update on the `clk` rising edge.
- **Reset:** `ctrl_state`=RUN and `stall_cycles`=0. While `rst_n`=0, all `stall_n` are forced to 1 and all flush outputs to 0.
- **Reset mid-MDU or mid-REDIR:** the block returns to RUN immediately and asynchronously.
- **Load-use bubble:** exactly one cycle. The next cycle the load is in MEM, so no match occurs.
- **Same-cycle MDU start and done:** `ex_mdu_start` && `mdu_done` together cause no stall and no state change.
- **Memory wait during MDU_WAIT:** the state is kept. `mdu_done` arriving during the memory wait still moves the FSM to RUN.
- **Redirect during memory wait:** deferred. EX is frozen, so `ex_redirect` stays asserted and takes effect on the first non-frozen cycle.

## Test plan
- **Load-use:** load x5 in EX, ID reads `id_rs1`=5 → one cycle with `stall_n_pc`=`stall_n_id`=0 and `flush_ex`=1. Repeat with `ex_rd`=0 → no stall.
- **MDU:** `ex_mdu_start` at cycle 0, `mdu_done` at cycle 4 → `ctrl_state`=1 for cycles 1–4; PC, ID and EX hold with `flush_mem`=1 for cycles 0–3; RUN at cycle 5; `stall_cycles`=4.
- **Redirect:** `ex_redirect` at cycle 0, `imem_ready`=0 at cycle 1 and 1 at cycle 2 → `flush_id`=`flush_ex`=1 at cycle 0; `flush_id`=1 at cycles 1–2; RUN at cycle 3.
- **Memory wait:** `dmem_req`=1 with `dmem_ready` low for 3 cycles and a simultaneous load-use hazard → only rule 1 outputs for 3 cycles, then the load-use bubble; `stall_cycles`=4.
- **Reset mid-MDU:** `rst_n` low during MDU_WAIT → state=0 and counter=0 immediately; all `stall_n`=1 while low.
- **Counter saturation:** with CNT_W=4 and a 20-cycle fetch stall → `stall_cycles`=15.
